dma_rd_streamer: RTL

DMA_RD_STREAMER -- requirements
Module: dma_rd_streamer

---
 rtl/dma_rd_streamer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dma_rd_streamer.sv
// rtl/dma_rd_streamer.sv - AXI4 read-burst DMA streamer: descriptor to AR bursts to output stream
module dma_rd_streamer #(
   parameter int MAX_BURST = 16,
   parameter int ID_W      = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      dma_req_i,
   input  logic [31:0]     desc_src_addr_i,
   input  logic [31:0]     desc_num_bytes_i,
   input  logic            abort_i,
   output logic            dma_done_o,
   output logic            axi_pend_txn_o,
   output logic [34:0]     rd_txn_err_o,
   output logic            arvalid_o,
   input  logic            arready_i,
   output logic [31:0]     araddr_o,
   output logic [7:0]      arlen_o,
   output logic [2:0]      arsize_o,
   output logic [1:0]      arburst_o,
   output logic [ID_W-1:0] arid_o,
   input  logic            rvalid_i,
   output logic            rready_o,
   input  logic [31:0]     rdata_i,
   input  logic [1:0]      rresp_i,
   input  logic            rlast_i,
   output logic            m_tvalid_o,
   input  logic            m_tready_i,
   output logic [31:0]     m_tdata_o,
   output logic            m_tlast_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_RD   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [30:0] beats_left_q, beats_left_d;
   logic [31:0] burst_base_q, burst_base_d;
   logic [8:0]  beat_idx_q, beat_idx_d;
   logic        abort_q, abort_d;
   logic [34:0] err_q, err_d;

   logic [10:0] words_to_4k;
   logic [30:0] len_full;
   logic [8:0]  burst_len;
   logic [8:0]  len_m1;
   logic        st_ar;
   logic        st_rd;
   logic        r_hs;
   logic        abort_any;
   logic        unused_ok;

   // Burst length: limited by remaining beats, MAX_BURST and the next 4 KB page boundary
   always_comb begin
      words_to_4k = 11'd1024 - {1'b0, addr_q[11:2]};
      len_full    = beats_left_q;
      if (len_full > 31'(MAX_BURST)) begin
         len_full = 31'(MAX_BURST);
      end
      if (len_full > {20'd0, words_to_4k}) begin
         len_full = {20'd0, words_to_4k};
      end
      burst_len = len_full[8:0];
      len_m1    = burst_len - 9'd1;
   end

   // The descriptor index only selects the externally muxed descriptor fields
   assign unused_ok = &{1'b0, dma_req_i[2:0], len_full[30:9], len_m1[8]};

   // Outputs are decodes of registered state; reset forces them quiet immediately
   assign st_ar          = (state_q == ST_AR) && !rst;
   assign st_rd          = (state_q == ST_RD) && !rst;
   assign arvalid_o      = st_ar && !abort_q;
   assign araddr_o       = st_ar ? addr_q : 32'd0;
   assign arlen_o        = st_ar ? len_m1[7:0] : 8'd0;
   assign arsize_o       = st_ar ? 3'b010 : 3'b000;
   assign arburst_o      = st_ar ? 2'b01 : 2'b00;
   assign arid_o         = {ID_W{1'b0}};
   assign rready_o       = st_rd && m_tready_i;
   assign m_tvalid_o     = st_rd && rvalid_i;
   assign m_tdata_o      = st_rd ? rdata_i : 32'd0;
   assign m_tlast_o      = st_rd && rvalid_i && rlast_i && (beats_left_q == 31'd0);
   assign dma_done_o     = (state_q == ST_DONE) && !rst;
   assign axi_pend_txn_o = st_ar || st_rd;
   assign rd_txn_err_o   = rst ? 35'd0 : err_q;

   assign r_hs      = st_rd && rvalid_i && m_tready_i;
   assign abort_any = abort_q || abort_i;

   // Next-state logic for the request / address / read-data sequence
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beats_left_d = beats_left_q;
      burst_base_d = burst_base_q;
      beat_idx_d   = beat_idx_q;
      abort_d      = abort_q;
      err_d        = err_q;
      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (dma_req_i[3]) begin
               addr_d       = {desc_src_addr_i[31:2], 2'b00};
               beats_left_d = {1'b0, desc_num_bytes_i[31:2]} + {30'd0, |desc_num_bytes_i[1:0]};
               err_d        = 35'd0;
               state_d      = (desc_num_bytes_i == 32'd0) ? ST_DONE : ST_AR;
            end
         end
         ST_AR: begin
            abort_d = abort_any;
            if (abort_q) begin
               state_d = ST_DONE;
            end else if (arready_i) begin
               state_d      = ST_RD;
               burst_base_d = addr_q;
               addr_d       = addr_q + {21'd0, burst_len, 2'b00};
               beats_left_d = beats_left_q - {22'd0, burst_len};
               beat_idx_d   = 9'd0;
            end
         end
         ST_RD: begin
            abort_d = abort_any;
            if (r_hs) begin
               beat_idx_d = beat_idx_q + 9'd1;
               if ((rresp_i != 2'b00) && !err_q[0]) begin
                  err_d = {burst_base_q + {21'd0, beat_idx_q, 2'b00}, 1'b0, 1'b0, 1'b1};
               end
               if (rlast_i) begin
                  state_d = ((beats_left_q != 31'd0) && !abort_any) ? ST_AR : ST_DONE;
               end
            end
         end
         default: begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= 32'd0;
         beats_left_q <= 31'd0;
         burst_base_q <= 32'd0;
         beat_idx_q   <= 9'd0;
         abort_q      <= 1'b0;
         err_q        <= 35'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beats_left_q <= beats_left_d;
         burst_base_q <= burst_base_d;
         beat_idx_q   <= beat_idx_d;
         abort_q      <= abort_d;
         err_q        <= err_d;
      end
   end

endmodule
